correlator_frame_rx: RTL and testbench
======================================

// Module: correlator_frame_rx
// PURPOSE
//  Receive-side decoder for the correlator's UART counter frame. Takes bytes from a byte-level UART
//  receiver, finds frame boundaries from line-idle gaps, and rebuilds the counter words.
//  Streams each word out on a valid/ready port, then checks the 8-byte trailer. Sits on the
//  host/aggregator FPGA, downstream of its uart_rx.
// PARAMETERS
//  RESOLUTION   16      counter word width in bits; must be a multiple of 8 (BPW = RESOLUTION/8)
//  NUM_INPUTS   4       inputs of the remote correlator
//  DELAY_LINES  21      delay taps per correlator pair
//  GAP_CYCLES   20000   idle clk cycles that mark an inter-frame gap (>= 2 byte times)
//  derived: NUM_WORDS = NUM_INPUTS*(NUM_INPUTS-1)/2*DELAY_LINES + NUM_INPUTS (130 at defaults)
// PORTS
//  clk          in   1           single clock; all logic on posedge
//  reset_n      in   1           asynchronous, active-low reset
//  rx_byte      in   8           received byte; valid only while rx_valid=1
//  rx_valid     in   1           one-cycle strobe per received byte
//  word_data    out  RESOLUTION  reassembled counter word
//  word_index   out  16          word position in frame, 0..NUM_WORDS-1
//  word_valid   out  1           word_data/word_index valid
//  word_ready   in   1           consumer accepts when word_valid & word_ready
//  frame_done   out  1           one-cycle pulse: trailer fully received and checked
//  frame_ok     out  1           result of last check; held until the next frame_done
//  frame_leds   out  32          LED word from the last good trailer
//  overflow     out  1           sticky: a word was dropped in the current frame
//  sync_err     out  1           one-cycle pulse: frame aborted by a gap, or a trailer mismatch
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; gap counter 0, so the line must first be idle for
//    GAP_CYCLES before any frame is accepted.
//  - Gap counter: cleared by each rx_valid; otherwise increments and saturates at GAP_CYCLES.
//  - Wire format, little-endian, no header:
//    NUM_WORDS*BPW payload bytes (word 0 first, LSB byte first), then 8 trailer bytes:
//    leds[7:0], leds[15:8], leds[23:16], leds[31:24], DELAY_LINES, NUM_INPUTS, RESOLUTION, 0x00.
//  - IDLE:
//    - rx_valid with gap saturated -> PAYLOAD; that byte is byte 0 of word 0.
//    - On that same cycle, clear overflow.
//    - rx_valid with gap not saturated -> byte dropped; stay in IDLE (resync).
//  - PAYLOAD:
//    - Each byte shifts into the word assembler at position byte_idx.
//    - On byte BPW-1, the word completes. One cycle later it is in the output register:
//      word_valid=1 and word_index = word count.
//    - After word NUM_WORDS-1 completes -> TRAILER.
//  - Output register, 1 entry:
//    - word_valid holds, with data stable, until word_valid & word_ready.
//    - A word completes while word_valid=1 and word_ready=0 -> new word discarded, overflow=1.
//    - A word completes in the same cycle as the handshake -> new word loads, no overflow.
//  - TRAILER: collect the 8 bytes. After the 8th byte -> CHECK (1 cycle) -> IDLE.
//  - CHECK:
//    - frame_done=1.
//    - frame_ok = (bytes 4..7 == {DELAY_LINES[7:0], NUM_INPUTS[7:0], RESOLUTION[7:0], 0}) & ~overflow.
//    - Only if the trailer bytes match: frame_leds <= bytes 0..3, overflow or not.
//    - Trailer mismatch -> also pulse sync_err.
//  - Abort: in PAYLOAD or TRAILER, gap reaches GAP_CYCLES -> sync_err pulse, go to IDLE.
//    - Abort clears the partial word and the indices.
//    - No frame_done on abort; frame_ok and frame_leds keep their old values.
//    - A word already in the output register is still delivered.
//  - A byte arriving right after the trailer lands in IDLE with gap=0: dropped, forces resync.
//  - reset_n low mid-frame: everything returns to reset values at once; the partial frame is lost.
// TESTING
//  1 Defaults, idle 20000 cycles, send one frame (word k = 16'h0100+k; trailer leds=32'hA5A5_0F0F,
//    21, 4, 16, 0), word_ready=1
//    -> 130 words, word_index 0..129, data 16'h0100..16'h0181.
//    -> frame_done once; frame_ok=1; frame_leds=32'hA5A5_0F0F.
//  2 As 1, but the trailer byte 21 is sent as 22
//    -> frame_done, frame_ok=0, sync_err pulse, frame_leds unchanged.
//  3 word_ready=0 for the whole frame
//    -> word_valid holds word 0 (16'h0100); overflow=1 from word 1 on; frame_ok=0.
//    -> frame_leds still updates (trailer matched).
//  4 Stop sending after 101 bytes, idle GAP_CYCLES
//    -> one sync_err; no frame_done; next full frame after the gap decodes with frame_ok=1.
//  5 After reset, send bytes before GAP_CYCLES of idle -> all dropped, no word_valid.
//    -> After the gap, the next frame decodes normally.
//  6 reset_n low at word 60 -> all outputs 0; the following frame decodes with frame_ok=1.

Source files
------------

// File: rtl/correlator_frame_rx.sv
// Receive-side decoder for the correlator UART counter frame.
// Splits frames on line-idle gaps, rebuilds words, checks trailer.
module correlator_frame_rx #(
  parameter int RESOLUTION  = 16,
  parameter int NUM_INPUTS  = 4,
  parameter int DELAY_LINES = 21,
  parameter int GAP_CYCLES  = 20000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic [RESOLUTION-1:0] word_data,
  output logic [15:0]           word_index,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [31:0]           frame_leds,
  output logic                  overflow,
  output logic                  sync_err
);

  localparam int BPW = RESOLUTION / 8;
  localparam int NUM_WORDS =
    NUM_INPUTS * (NUM_INPUTS - 1) / 2 * DELAY_LINES + NUM_INPUTS;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int GW  = $clog2(GAP_CYCLES + 1);

  localparam logic [GW-1:0]  GAP_MAX = GW'(GAP_CYCLES);
  localparam logic [BIW-1:0] BI_LAST = BIW'(BPW - 1);
  localparam logic [15:0]    WC_LAST = 16'(NUM_WORDS - 1);
  localparam logic [31:0]    TRL_EXP = {8'h00, 8'(RESOLUTION),
                                        8'(NUM_INPUTS), 8'(DELAY_LINES)};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_TRAILER,
    S_CHECK
  } state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [RESOLUTION-1:0] acc_q, acc_d;
  logic [BIW-1:0]        byte_idx_q, byte_idx_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [2:0]            trl_idx_q, trl_idx_d;
  logic [63:0]           trl_q, trl_d;
  logic [RESOLUTION-1:0] word_data_q, word_data_d;
  logic [15:0]           word_index_q, word_index_d;
  logic                  word_valid_q, word_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_ok_q, frame_ok_d;
  logic [31:0]           leds_q, leds_d;
  logic                  sync_err_q, sync_err_d;

  logic                  gap_sat;
  logic                  take;
  logic                  abort;
  logic                  word_done;
  logic                  match;
  logic [RESOLUTION-1:0] word_new;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    byte_idx_d   = byte_idx_q;
    word_cnt_d   = word_cnt_q;
    trl_idx_d    = trl_idx_q;
    trl_d        = trl_q;
    word_data_d  = word_data_q;
    word_index_d = word_index_q;
    word_valid_d = word_valid_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    leds_d       = leds_q;
    sync_err_d   = 1'b0;
    take         = 1'b0;
    abort        = 1'b0;
    word_done    = 1'b0;
    match        = 1'b0;

    gap_sat = (gap_q == GAP_MAX);
    if (rx_valid) gap_d = '0;
    else if (gap_sat) gap_d = gap_q;
    else gap_d = gap_q + GW'(1);

    word_new = acc_q;
    word_new[8*int'(byte_idx_q) +: 8] = rx_byte;

    if (word_valid_q && word_ready) word_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && gap_sat) begin
          take       = 1'b1;
          overflow_d = 1'b0;
          state_d    = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (gap_sat) abort = 1'b1;
        else if (rx_valid) take = 1'b1;
      end
      S_TRAILER: begin
        if (gap_sat) begin
          abort = 1'b1;
        end else if (rx_valid) begin
          trl_d[8*int'(trl_idx_q) +: 8] = rx_byte;
          trl_idx_d = trl_idx_q + 3'd1;
          if (trl_idx_q == 3'd7) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        match        = (trl_q[63:32] == TRL_EXP);
        frame_done_d = 1'b1;
        frame_ok_d   = match & ~overflow_q;
        if (match) leds_d = trl_q[31:0];
        else sync_err_d = 1'b1;
        trl_idx_d    = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      if (byte_idx_q == BI_LAST) begin
        word_done  = 1'b1;
        acc_d      = '0;
        byte_idx_d = '0;
        word_cnt_d = word_cnt_q + 16'd1;
        if (word_cnt_q == WC_LAST) begin
          word_cnt_d = '0;
          state_d    = S_TRAILER;
        end
      end else begin
        acc_d      = word_new;
        byte_idx_d = byte_idx_q + BIW'(1);
      end
    end

    // single-entry output stage: a busy register drops the new word
    if (word_done) begin
      if (!word_valid_q || word_ready) begin
        word_data_d  = word_new;
        word_index_d = word_cnt_q;
        word_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (abort) begin
      sync_err_d = 1'b1;
      state_d    = S_IDLE;
      acc_d      = '0;
      byte_idx_d = '0;
      word_cnt_d = '0;
      trl_idx_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      gap_q        <= '0;
      acc_q        <= '0;
      byte_idx_q   <= '0;
      word_cnt_q   <= '0;
      trl_idx_q    <= '0;
      trl_q        <= '0;
      word_data_q  <= '0;
      word_index_q <= '0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      leds_q       <= '0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      acc_q        <= acc_d;
      byte_idx_q   <= byte_idx_d;
      word_cnt_q   <= word_cnt_d;
      trl_idx_q    <= trl_idx_d;
      trl_q        <= trl_d;
      word_data_q  <= word_data_d;
      word_index_q <= word_index_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      leds_q       <= leds_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign word_data  = word_data_q;
  assign word_index = word_index_q;
  assign word_valid = word_valid_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign frame_leds = leds_q;
  assign overflow   = overflow_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_correlator_frame_rx.sv
// Bench for correlator_frame_rx: frames built from the wire format,
// decoded words and trailer results compared to the built frame.
module tb_correlator_frame_rx;

  localparam int RES = 16;
  localparam int NI  = 4;
  localparam int DL  = 21;
  localparam int GAP = 64;
  localparam int BPW = RES / 8;
  localparam int NW  = NI * (NI - 1) / 2 * DL + NI;

  logic           clk;
  logic           reset_n;
  logic [7:0]     rx_byte;
  logic           rx_valid;
  logic [RES-1:0] word_data;
  logic [15:0]    word_index;
  logic           word_valid;
  logic           word_ready;
  logic           frame_done;
  logic           frame_ok;
  logic [31:0]    frame_leds;
  logic           overflow;
  logic           sync_err;

  correlator_frame_rx #(
    .RESOLUTION(RES),
    .NUM_INPUTS(NI),
    .DELAY_LINES(DL),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .word_data(word_data),
    .word_index(word_index),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .frame_done(frame_done),
    .frame_ok(frame_ok),
    .frame_leds(frame_leds),
    .overflow(overflow),
    .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0]    got_q[$];
  logic [15:0]    exp_w[$];
  logic [7:0]     tx_q[$];
  int             done_cnt = 0;
  int             err_cnt = 0;
  logic           last_ok = 1'b0;
  logic [31:0]    cur_leds = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (word_valid && word_ready) got_q.push_back({word_index, word_data});
      if (frame_done) begin
        done_cnt++;
        last_ok = frame_ok;
      end
      if (sync_err) err_cnt++;
    end
  end

  task automatic build_frame(input bit rnd, input logic [31:0] leds,
                             input logic [7:0] dl);
    logic [15:0] w;
    exp_w.delete();
    tx_q.delete();
    for (int k = 0; k < NW; k++) begin
      w = rnd ? 16'($urandom) : 16'(16'h0100 + k);
      exp_w.push_back(w);
      for (int b = 0; b < BPW; b++) tx_q.push_back(w[8*b +: 8]);
    end
    for (int b = 0; b < 4; b++) tx_q.push_back(leds[8*b +: 8]);
    tx_q.push_back(dl);
    tx_q.push_back(8'(NI));
    tx_q.push_back(8'(RES));
    tx_q.push_back(8'h00);
  endtask

  task automatic send_bytes(input int n, input int max_sp, input int ready_at);
    int sp;
    for (int i = 0; i < n; i++) begin
      rx_byte  = tx_q[i];
      rx_valid = 1'b1;
      if (i == ready_at) word_ready = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      sp = $urandom_range(max_sp, 0);
      repeat (sp) begin @(posedge clk); #1; end
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    got_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    rx_valid   = 1'b0;
    rx_byte    = '0;
    word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({word_valid, word_data, word_index} !== '0) begin
      n_fail++;
      $display("FAIL reset_word: got %0b/%0h/%0d want 0", word_valid,
               word_data, word_index);
    end
    n_chk++;
    if ({frame_done, frame_ok, overflow, sync_err, frame_leds} !== '0) begin
      n_fail++;
      $display("FAIL reset_status: got %0b%0b%0b%0b leds %0h want 0",
               frame_done, frame_ok, overflow, sync_err, frame_leds);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset_gap();
    clear_mon();
    build_frame(1'b1, 32'h1234_5678, 8'(DL));
    send_bytes(10, 3, -1);
    idle(5);
    n_chk++;
    if (got_q.size() != 0 || word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL early_drop: got %0d words valid %0b want 0",
               got_q.size(), word_valid);
    end
    idle(GAP + 4);
    clear_mon();
    cur_leds = $urandom;
    build_frame(1'b1, cur_leds, 8'(DL));
    send_bytes(tx_q.size(), 3, -1);
    idle(10);
    n_chk++;
    if (got_q.size() != NW) begin
      n_fail++;
      $display("FAIL gap_frame_count: got %0d want %0d", got_q.size(), NW);
    end
    for (int k = 0; k < NW && k < got_q.size(); k++) begin
      n_chk++;
      if (got_q[k] !== {16'(k), exp_w[k]}) begin
        n_fail++;
        $display("FAIL gap_frame_word: got %h want %h", got_q[k],
                 {16'(k), exp_w[k]});
      end
    end
    n_chk++;
    if (done_cnt != 1 || last_ok !== 1'b1 || frame_leds !== cur_leds) begin
      n_fail++;
      $display("FAIL gap_frame_done: got %0d/%0b/%h want 1/1/%h",
               done_cnt, last_ok, frame_leds, cur_leds);
    end
  endtask

  task automatic test_basic();
    idle(GAP + 4);
    clear_mon();
    cur_leds = 32'hA5A5_0F0F;
    build_frame(1'b0, cur_leds, 8'(DL));
    send_bytes(tx_q.size(), 3, -1);
    idle(10);
    n_chk++;
    if (got_q.size() != NW) begin
      n_fail++;
      $display("FAIL basic_count: got %0d want %0d", got_q.size(), NW);
    end
    for (int k = 0; k < NW && k < got_q.size(); k++) begin
      n_chk++;
      if (got_q[k] !== {16'(k), exp_w[k]}) begin
        n_fail++;
        $display("FAIL basic_word: got %h want %h", got_q[k],
                 {16'(k), exp_w[k]});
      end
    end
    n_chk++;
    if (done_cnt != 1 || last_ok !== 1'b1 || err_cnt != 0) begin
      n_fail++;
      $display("FAIL basic_done: got done %0d ok %0b err %0d want 1/1/0",
               done_cnt, last_ok, err_cnt);
    end
    n_chk++;
    if (frame_leds !== cur_leds || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_leds: got %h ovf %0b want %h ovf 0",
               frame_leds, overflow, cur_leds);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      idle(GAP + 4);
      clear_mon();
      cur_leds = $urandom;
      build_frame(1'b1, cur_leds, 8'(DL));
      send_bytes(tx_q.size(), (f == 0) ? 0 : 2, -1);
      idle(10);
      n_chk++;
      if (got_q.size() != NW) begin
        n_fail++;
        $display("FAIL b2b_count: got %0d want %0d", got_q.size(), NW);
      end
      for (int k = 0; k < NW && k < got_q.size(); k++) begin
        n_chk++;
        if (got_q[k] !== {16'(k), exp_w[k]}) begin
          n_fail++;
          $display("FAIL b2b_word: got %h want %h", got_q[k],
                   {16'(k), exp_w[k]});
        end
      end
      n_chk++;
      if (done_cnt != 1 || last_ok !== 1'b1 || frame_leds !== cur_leds) begin
        n_fail++;
        $display("FAIL b2b_done: got %0d/%0b/%h want 1/1/%h",
                 done_cnt, last_ok, frame_leds, cur_leds);
      end
    end
  endtask

  task automatic test_trailer_mismatch();
    idle(GAP + 4);
    clear_mon();
    build_frame(1'b1, 32'hDEAD_BEEF, 8'(DL + 1));
    send_bytes(tx_q.size(), 3, -1);
    idle(10);
    n_chk++;
    if (done_cnt != 1 || last_ok !== 1'b0 || err_cnt != 1) begin
      n_fail++;
      $display("FAIL mismatch_done: got done %0d ok %0b err %0d want 1/0/1",
               done_cnt, last_ok, err_cnt);
    end
    n_chk++;
    if (frame_leds !== cur_leds) begin
      n_fail++;
      $display("FAIL mismatch_leds: got %h want %h", frame_leds, cur_leds);
    end
  endtask

  task automatic test_no_ready();
    idle(GAP + 4);
    clear_mon();
    word_ready = 1'b0;
    cur_leds = $urandom;
    build_frame(1'b1, cur_leds, 8'(DL));
    send_bytes(tx_q.size(), 3, -1);
    idle(10);
    n_chk++;
    if (word_valid !== 1'b1 || word_data !== exp_w[0] ||
        word_index !== 16'd0) begin
      n_fail++;
      $display("FAIL noready_hold: got %0b/%h/%0d want 1/%h/0",
               word_valid, word_data, word_index, exp_w[0]);
    end
    n_chk++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL noready_ovf: got %0b want 1", overflow);
    end
    n_chk++;
    if (done_cnt != 1 || last_ok !== 1'b0 || err_cnt != 0) begin
      n_fail++;
      $display("FAIL noready_done: got done %0d ok %0b err %0d want 1/0/0",
               done_cnt, last_ok, err_cnt);
    end
    n_chk++;
    if (frame_leds !== cur_leds) begin
      n_fail++;
      $display("FAIL noready_leds: got %h want %h", frame_leds, cur_leds);
    end
    word_ready = 1'b1;
    idle(3);
  endtask

  task automatic test_abort();
    logic [31:0] prev_leds;
    prev_leds = cur_leds;
    idle(GAP + 4);
    clear_mon();
    build_frame(1'b1, 32'h0BAD_F00D, 8'(DL));
    send_bytes(101, 3, -1);
    idle(GAP + 10);
    n_chk++;
    if (err_cnt != 1 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_err: got err %0d done %0d want 1/0",
               err_cnt, done_cnt);
    end
    n_chk++;
    if (got_q.size() != 50) begin
      n_fail++;
      $display("FAIL abort_words: got %0d want 50", got_q.size());
    end
    n_chk++;
    if (frame_ok !== 1'b0 || frame_leds !== prev_leds || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_hold: got ok %0b leds %h ovf %0b want 0/%h/0",
               frame_ok, frame_leds, overflow, prev_leds);
    end
    clear_mon();
    cur_leds = $urandom;
    build_frame(1'b1, cur_leds, 8'(DL));
    send_bytes(tx_q.size(), 3, -1);
    idle(10);
    n_chk++;
    if (got_q.size() != NW || done_cnt != 1 || last_ok !== 1'b1 ||
        frame_leds !== cur_leds) begin
      n_fail++;
      $display("FAIL abort_next: got %0d words done %0d ok %0b leds %h want %0d/1/1/%h",
               got_q.size(), done_cnt, last_ok, frame_leds, NW, cur_leds);
    end
  endtask

  task automatic test_collision();
    idle(GAP + 4);
    clear_mon();
    word_ready = 1'b0;
    cur_leds = $urandom;
    build_frame(1'b1, cur_leds, 8'(DL));
    send_bytes(tx_q.size(), 0, 2 * BPW - 1);
    idle(10);
    n_chk++;
    if (got_q.size() != NW || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_count: got %0d ovf %0b want %0d ovf 0",
               got_q.size(), overflow, NW);
    end
    for (int k = 0; k < NW && k < got_q.size(); k++) begin
      n_chk++;
      if (got_q[k] !== {16'(k), exp_w[k]}) begin
        n_fail++;
        $display("FAIL collide_word: got %h want %h", got_q[k],
                 {16'(k), exp_w[k]});
      end
    end
    n_chk++;
    if (done_cnt != 1 || last_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_done: got %0d/%0b want 1/1", done_cnt, last_ok);
    end
  endtask

  task automatic test_reset_mid();
    idle(GAP + 4);
    clear_mon();
    build_frame(1'b1, 32'h5555_AAAA, 8'(DL));
    send_bytes(120, 2, -1);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({word_valid, word_data, word_index, frame_done, frame_ok,
         frame_leds, overflow, sync_err} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v%0b d%h i%0d ok%0b leds%h want 0",
               word_valid, word_data, word_index, frame_ok, frame_leds);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_mon();
    idle(GAP + 4);
    cur_leds = $urandom;
    build_frame(1'b1, cur_leds, 8'(DL));
    send_bytes(tx_q.size(), 3, -1);
    idle(10);
    n_chk++;
    if (got_q.size() != NW) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d want %0d", got_q.size(), NW);
    end
    for (int k = 0; k < NW && k < got_q.size(); k++) begin
      n_chk++;
      if (got_q[k] !== {16'(k), exp_w[k]}) begin
        n_fail++;
        $display("FAIL midreset_word: got %h want %h", got_q[k],
                 {16'(k), exp_w[k]});
      end
    end
    n_chk++;
    if (done_cnt != 1 || last_ok !== 1'b1 || frame_leds !== cur_leds) begin
      n_fail++;
      $display("FAIL midreset_done: got %0d/%0b/%h want 1/1/%h",
               done_cnt, last_ok, frame_leds, cur_leds);
    end
  endtask

  initial begin
    test_reset();
    test_reset_gap();
    test_basic();
    test_back_to_back();
    test_trailer_mismatch();
    test_no_ready();
    test_abort();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
